// File: rtl/or_gate_bist.sv
// Purpose: exhaustive built-in self test of a WIDTH-input OR gate. Every vector is applied, the response is compared, and failing vectors are captured.
// Latency: each vector takes SETTLE+1 cycles, so a run takes 2^WIDTH*(SETTLE+1) cycles of busy, followed by a one-cycle done pulse.
// Backpressure: err_valid/err_ready pops the capture FIFO; a failing vector that finds the FIFO full (and no pop that cycle) is dropped and overflow sticks.
module or_gate_bist #(
    parameter int               WIDTH  = 10,
    parameter logic [WIDTH-1:0] MASK   = 10'h1FF,
    parameter int               SETTLE = 1,
    parameter int               DEPTH  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] dut_i,
    input  logic             dut_o,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH:0]   err_count,
    output logic             err_valid,
    input  logic             err_ready,
    output logic [WIDTH-1:0] err_data,
    output logic             overflow
);

    // DEPTH is a power of two >= 2, so pointers wrap naturally at AW bits
    localparam int AW = $clog2(DEPTH);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        APPLY   = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [SW-1:0]    settle_cnt;

    logic             start_run;
    logic             expected;
    logic             mismatch;
    logic [WIDTH:0]   err_count_nxt;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      fifo_cnt;
    logic             full;
    logic             push;
    logic             pop;
    logic             drop;

    // Next-state decode and status outputs derived from the current state
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = APPLY;
            end
            APPLY: begin
                busy = 1'b1;
                if (settle_cnt == SW'(SETTLE - 1)) state_nxt = COMPARE;
            end
            COMPARE: begin
                busy = 1'b1;
                if (dut_i == '1) state_nxt = DONE;
                else             state_nxt = APPLY;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Response check and FIFO handshake qualifiers
    always_comb begin
        start_run     = (state == IDLE) && start;
        expected      = |(dut_i & MASK);
        mismatch      = (state == COMPARE) && (dut_o != expected);
        err_count_nxt = err_count + (WIDTH + 1)'(mismatch);
        full          = (fifo_cnt == (AW + 1)'(DEPTH));
        err_valid     = (fifo_cnt != '0);
        pop           = err_valid && err_ready;
        // a pop on the same edge frees the slot, so a full FIFO still accepts
        push          = mismatch && (!full || pop);
        drop          = mismatch && full && !pop;
        err_data      = err_valid ? mem[rd_ptr] : '0;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Counts the hold cycles of the current vector while in APPLY
    always_ff @(posedge clk) begin
        if (rst)                                          settle_cnt <= '0;
        else if (state == APPLY && state_nxt == APPLY)    settle_cnt <= settle_cnt + SW'(1);
        else                                              settle_cnt <= '0;
    end

    // Stimulus vector: cleared at run start, stepped after each compare, held at the end
    always_ff @(posedge clk) begin
        if (rst)                                        dut_i <= '0;
        else if (start_run)                             dut_i <= '0;
        else if (state == COMPARE && dut_i != '1)       dut_i <= dut_i + WIDTH'(1);
    end

    // Run results: mismatch count, sticky overflow, and pass latched on the way into DONE
    always_ff @(posedge clk) begin
        if (rst || start_run) begin
            err_count <= '0;
            overflow  <= 1'b0;
            pass      <= 1'b0;
        end else if (state == COMPARE) begin
            err_count <= err_count_nxt;
            if (drop)               overflow <= 1'b1;
            if (state_nxt == DONE)  pass     <= (err_count_nxt == '0);
        end
    end

    // Capture FIFO pointers and occupancy; reset and run start empty it
    always_ff @(posedge clk) begin
        if (rst || start_run) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (AW + 1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (AW + 1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Capture FIFO storage; contents are masked by err_valid so no reset is needed
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= dut_i;
    end

endmodule

// File: tb/tb_or_gate_bist.sv
// Bench for or_gate_bist: drives a configurable fake OR gate and checks results against a vector-by-vector reference.
// Each run is compared with a failing-vector list built directly from the OR rule.
// Covers reset, capture-FIFO drain and overflow, run length, and start being ignored while busy.
module tb_or_gate_bist;

    localparam int         W        = 10;
    localparam int         DEPTH    = 8;
    localparam logic [9:0] REF_MASK = 10'h1FF;
    localparam int         RUN_LEN  = 2048;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [9:0] dut_i;
    logic       dut_o;
    logic       busy;
    logic       done;
    logic       pass;
    logic [10:0] err_count;
    logic       err_valid;
    logic       err_ready;
    logic [9:0] err_data;
    logic       overflow;

    // fake-DUT configuration: OR over dmask, optionally inverted where (v & fmask) == fval
    logic [9:0] m_dmask = 10'h1FF;
    logic       m_flip  = 1'b0;
    logic [9:0] m_fmask = 10'h000;
    logic [9:0] m_fval  = 10'h000;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [9:0] dmask;
        logic       flip;
        logic [9:0] fmask;
        logic [9:0] fval;
        logic       rdy;
        logic       restart;
        logic       use_model;
        int         exp_count;
        logic       exp_pass;
        logic       exp_ovf;
    } vec_t;

    vec_t tbl [7];

    or_gate_bist #(
        .WIDTH (10),
        .MASK  (10'h1FF),
        .SETTLE(1),
        .DEPTH (8)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dut_i    (dut_i),
        .dut_o    (dut_o),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_count(err_count),
        .err_valid(err_valid),
        .err_ready(err_ready),
        .err_data (err_data),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic fake_dut(input logic [9:0] v, input logic [9:0] dm,
                                      input logic fl, input logic [9:0] fm, input logic [9:0] fv);
        return (|(v & dm)) ^ (fl && ((v & fm) == fv));
    endfunction

    always_comb dut_o = fake_dut(dut_i, m_dmask, m_flip, m_fmask, m_fval);

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // One complete run with table entry t; FIFO output is collected and compared at the end
    task automatic do_run(input int idx, input vec_t t);
        logic [9:0] fails [$];
        logic [9:0] got [$];
        int  n, exp_cnt, nexp, bad, busy_cnt, done_cnt;
        logic exp_ps, exp_ov;
        bit  fin;
        busy_cnt = 0;
        done_cnt = 0;
        fin      = 1'b0;
        // reference: every vector whose fake response differs from the OR of the masked bits
        for (int v = 0; v < (1 << W); v++) begin
            if (fake_dut(10'(v), t.dmask, t.flip, t.fmask, t.fval) != (|(10'(v) & REF_MASK)))
                fails.push_back(10'(v));
        end
        n = fails.size();
        if (t.use_model) begin
            exp_cnt = n;
            exp_ps  = (n == 0);
            exp_ov  = !t.rdy && (n > DEPTH);
        end else begin
            exp_cnt = t.exp_count;
            exp_ps  = t.exp_pass;
            exp_ov  = t.exp_ovf;
        end
        m_dmask   = t.dmask;
        m_flip    = t.flip;
        m_fmask   = t.fmask;
        m_fval    = t.fval;
        err_ready = t.rdy;
        start     = 1'b1;
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (t.restart && cyc == 500) start = 1'b1;
            if (busy) busy_cnt++;
            if (err_valid && err_ready) got.push_back(err_data);
            if (done) begin
                done_cnt++;
                fin = 1'b1;
                $display("run %0d: checking end of run", idx);
                check("pass", pass, exp_ps);
                check("err_count", err_count, exp_cnt);
                check("overflow", overflow, exp_ov);
                check("dut_i_last", dut_i, 10'h3FF);
                if (t.restart) start = 1'b1;
            end
        end
        check("done_seen", fin, 1);
        check("busy_cycles", busy_cnt, RUN_LEN);
        check("done_pulses", done_cnt, 1);
        @(negedge clk);
        start = 1'b0;
        check("idle_after_done", busy, 0);
        check("done_one_cycle", done, 0);
        check("dut_i_hold", dut_i, 10'h3FF);
        err_ready = 1'b1;
        if (err_valid) got.push_back(err_data);
        repeat (DEPTH + 4) begin
            @(negedge clk);
            if (err_valid) got.push_back(err_data);
        end
        err_ready = 1'b0;
        check("fifo_empty_valid", err_valid, 0);
        check("fifo_empty_data", err_data, 0);
        nexp = (t.rdy || n < DEPTH) ? n : DEPTH;
        check("fifo_entries", got.size(), nexp);
        bad = -1;
        for (int i = 0; i < got.size() && i < nexp; i++) begin
            if (bad < 0 && got[i] != fails[i]) bad = i;
        end
        check("fifo_order_first_bad_index", bad, -1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        err_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err_count", err_count, 0);
        check("rst_err_valid", err_valid, 0);
        check("rst_err_data", err_data, 0);
        check("rst_overflow", overflow, 0);
        check("rst_dut_i", dut_i, 0);

        // directed rows: correct gate (with stray starts), stuck-at-0 both ways, full 10-bit OR
        tbl[0] = '{10'h1FF, 1'b0, 10'h000, 10'h000, 1'b0, 1'b1, 1'b0, 0,    1'b1, 1'b0};
        tbl[1] = '{10'h000, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0, 1'b0, 1022, 1'b0, 1'b1};
        tbl[2] = '{10'h3FF, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0, 1'b0, 1,    1'b0, 1'b0};
        tbl[3] = '{10'h000, 1'b0, 10'h000, 10'h000, 1'b1, 1'b0, 1'b0, 1022, 1'b0, 1'b0};
        for (int i = 4; i < 7; i++) begin
            tbl[i].dmask     = 10'($urandom_range(0, 1023));
            tbl[i].flip      = 1'($urandom_range(0, 1));
            tbl[i].fmask     = 10'($urandom_range(0, 1023)) | 10'h300;
            tbl[i].fval      = 10'($urandom) & tbl[i].fmask;
            tbl[i].rdy       = 1'($urandom_range(0, 1));
            tbl[i].restart   = 1'b0;
            tbl[i].use_model = 1'b1;
            tbl[i].exp_count = 0;
            tbl[i].exp_pass  = 1'b0;
            tbl[i].exp_ovf   = 1'b0;
        end
        for (int i = 0; i < 7; i++) do_run(i, tbl[i]);

        // full FIFO, then pop on the same edge as the next push: both succeed, no overflow
        m_dmask   = 10'h000;
        m_flip    = 1'b0;
        err_ready = 1'b0;
        start     = 1'b1;
        begin
            bit seen8;
            seen8 = 1'b0;
            for (int cyc = 0; cyc < 100 && !seen8; cyc++) begin
                @(negedge clk);
                start = 1'b0;
                if (err_count == 11'd8) seen8 = 1'b1;
            end
            check("reach_full", seen8, 1);
        end
        check("full_valid", err_valid, 1);
        check("full_no_ovf", overflow, 0);
        @(negedge clk);
        check("compare_vec", dut_i, 10'h009);
        check("oldest_entry", err_data, 10'h001);
        err_ready = 1'b1;
        @(negedge clk);
        err_ready = 1'b0;
        check("push_pop_full_ovf", overflow, 0);
        check("push_pop_full_count", err_count, 9);
        check("push_pop_full_head", err_data, 10'h002);
        repeat (2) @(negedge clk);
        check("full_drop_ovf", overflow, 1);
        check("full_drop_count", err_count, 10);
        // reset wins over start and a pending pop
        rst       = 1'b1;
        start     = 1'b1;
        err_ready = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        start     = 1'b0;
        err_ready = 1'b0;
        check("rst_prio_busy", busy, 0);
        check("rst_prio_valid", err_valid, 0);
        check("rst_prio_ovf", overflow, 0);
        @(negedge clk);
        check("rst_prio_still_idle", busy, 0);

        // reset 100 cycles into a run
        start = 1'b1;
        repeat (100) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("mid_run_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_dut_i", dut_i, 0);
        check("mid_rst_err_count", err_count, 0);
        check("mid_rst_err_valid", err_valid, 0);
        check("mid_rst_pass", pass, 0);
        check("mid_rst_done", done, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/or_gate_bist.md
OR_GATE_BIST -- requirements
Module: or_gate_bist

Interface
REQ-001 SHALL have parameter WIDTH, default 10, meaning the DUT input vector width.
REQ-002 SHALL have parameter MASK, default 10'h1FF, meaning the DUT input bits that contribute to the expected OR result; unmasked bits are don't-care.
REQ-003 SHALL have parameter SETTLE, default 1, meaning the cycles (>=1) a vector is held before the DUT output is compared.
REQ-004 SHALL have parameter DEPTH, default 8, meaning the error-capture FIFO depth (power of 2).
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-007 SHALL have port start, input, 1, meaning a request to begin an exhaustive run; sampled only in IDLE.
REQ-008 SHALL have port dut_i, output, WIDTH, meaning the stimulus vector to the DUT; registered.
REQ-009 SHALL have port dut_o, input, 1, meaning the DUT response; combinational from dut_i.
REQ-010 SHALL have port busy, output, 1, meaning a run is in progress.
REQ-011 SHALL have port done, output, 1, meaning a one-cycle pulse at end of run.
REQ-012 SHALL have port pass, output, 1, meaning the last completed run had zero mismatches; held until next start.
REQ-013 SHALL have port err_count, output, WIDTH+1, meaning the mismatch count of the current/last run.
REQ-014 SHALL have port err_valid, output, 1, meaning the FIFO is non-empty and err_data is valid.
REQ-015 SHALL have port err_ready, input, 1, meaning the consumer accepts err_data.
REQ-016 SHALL have port err_data, output, WIDTH, meaning the oldest failing vector in the FIFO.
REQ-017 SHALL have port overflow, output, 1, meaning sticky: at least one failing vector was dropped because the FIFO was full.

Function
REQ-018 SHALL implement FSM states IDLE, APPLY, COMPARE, DONE.
REQ-019 IDLE: start=1 SHALL, at the next edge, clear err_count, overflow, pass and the FIFO, set dut_i=0 and busy=1, and enter APPLY.
REQ-020 APPLY SHALL hold dut_i for exactly SETTLE cycles, then enter COMPARE.
REQ-021 COMPARE SHALL last one cycle; expected = OR-reduce(dut_i & MASK); mismatch = (dut_o != expected), evaluated in that cycle.
REQ-022 On mismatch at the COMPARE-ending edge, err_count SHALL increment and dut_i SHALL be pushed to the FIFO if not full, else dropped and overflow set.
REQ-023 At the COMPARE-ending edge, if dut_i != all-ones, dut_i SHALL increment by 1 and the FSM SHALL enter APPLY; otherwise it SHALL enter DONE.
REQ-024 Vectors SHALL cover 0 to 2^WIDTH-1 inclusive, ascending, each exactly once; busy SHALL be high for exactly 2^WIDTH*(SETTLE+1) cycles (2048 at defaults).
REQ-025 DONE SHALL last one cycle with done=1, busy=0, pass=(err_count==0), then return to IDLE; dut_i SHALL hold its last value.
REQ-026 start while busy or in DONE SHALL be ignored.
REQ-027 The FIFO SHALL be first-in-first-out; a pop occurs when err_valid && err_ready; it SHALL be readable during and after a run.
REQ-028 When a push and a pop coincide while full, both SHALL succeed and overflow SHALL NOT be set.
REQ-029 err_valid SHALL rise the cycle after the first push into an empty FIFO; no fall-through within the push cycle.
REQ-030 err_count SHALL NOT wrap (max 2^WIDTH fits WIDTH+1 bits).

Reset
REQ-031 rst SHALL, at the next edge and regardless of state, force IDLE, dut_i=0, busy=0, done=0, pass=0, err_count=0, overflow=0, FIFO empty (err_valid=0, err_data=0).
REQ-032 rst SHALL take priority over start and over simultaneous FIFO push/pop.

Verification
REQ-033 Correct DUT (dut_o = |dut_i[8:0]), start pulse -> busy 2048 cycles, done pulse, pass=1, err_count=0, err_valid=0, overflow=0.
REQ-034 dut_o stuck at 0, err_ready=0 -> err_count=1022 (vectors 0 and 10'h200 match), FIFO reads 1..8 in order, overflow=1, pass=0.
REQ-035 DUT = |dut_i (all 10 bits) -> err_count=1, single entry err_data=10'h200, overflow=0, pass=0.
REQ-036 dut_o stuck at 0, err_ready=1 throughout -> all 1022 failing vectors read in ascending order, overflow=0; separately, hold full FIFO then pop on a push edge -> no overflow.
REQ-037 rst asserted 100 cycles into a run -> next cycle busy=0, dut_i=0, err_count=0, err_valid=0; start pulse during run -> ignored, run length unchanged.
